sdram_port_arbiter: RTL and testbench

Shares the single cache_ctrl user port (rd_en/wr_en pulse, addr, data, byte mask, busy) between N_PORTS requesters, e.g. per-hart AHB SRAM front ends. It arbitrates round-robin, sequences each access through the cache_ctrl busy handshake, and returns read data with a done pulse. It also hosts the load-reserved/store-conditional reservation monitor, so exclusive access is tracked across all requesters rather than per wrapper.

---
 rtl/sdram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one cache_ctrl user port among N_PORTS requesters,
// with a shared LR/SC reservation monitor. All outputs are registered.
module sdram_port_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PORTS-1:0]        p_req,
    input  logic [N_PORTS-1:0]        p_we,
    input  logic [N_PORTS-1:0]        p_excl,
    input  logic [N_PORTS*W_ADDR-1:0] p_addr,
    input  logic [N_PORTS*W_DATA-1:0] p_wdata,
    input  logic [N_PORTS*4-1:0]      p_mask,
    output logic [N_PORTS-1:0]        p_gnt,
    output logic [N_PORTS-1:0]        p_done,
    output logic [N_PORTS-1:0]        p_exokay,
    output logic [W_DATA-1:0]         p_rdata,
    output logic                      m_rd_en,
    output logic                      m_wr_en,
    output logic [W_ADDR-1:0]         m_addr,
    output logic [W_DATA-1:0]         m_wdata,
    output logic [3:0]                m_mask,
    input  logic [W_DATA-1:0]         m_rdata,
    input  logic                      m_busy
);
    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int WA = W_ADDR - 2;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP} state_t;
    state_t state, state_nx;

    logic [PW-1:0]      rr_ptr, sel, sel_c;
    logic               found, sc_ok;
    logic [W_ADDR-1:0]  req_addr;
    logic               we_q, excl_q, ok_q;
    logic [WA-1:0]      waddr_q;
    logic [W_DATA-1:0]  wdata_q;
    logic [3:0]         mask_q;
    logic [N_PORTS-1:0] res_vld;
    logic [WA-1:0]      res_addr [N_PORTS];

    logic [N_PORTS-1:0] gnt_nx, done_nx, exok_nx;
    logic               rd_nx, wr_nx;
    logic               unused_lo;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        sel_c = rr_ptr;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!found && p_req[(int'(rr_ptr) + k) % N_PORTS]) begin
                found = 1'b1;
                sel_c = PW'((int'(rr_ptr) + k) % N_PORTS);
            end
        end
    end

    assign req_addr = p_addr[int'(sel_c)*W_ADDR +: W_ADDR];
    assign sc_ok    = res_vld[sel_c] && (res_addr[sel_c] == req_addr[W_ADDR-1:2]);

    // Byte offsets never reach the memory side.
    always_comb begin
        unused_lo = 1'b0;
        for (int i = 0; i < N_PORTS; i++)
            unused_lo = unused_lo ^ (^p_addr[i*W_ADDR +: 2]);
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = '0;
        done_nx  = '0;
        exok_nx  = '0;
        rd_nx    = 1'b0;
        wr_nx    = 1'b0;
        case (state)
            IDLE: if (!m_busy && found) begin
                gnt_nx[sel_c] = 1'b1;
                state_nx = (p_we[sel_c] && p_excl[sel_c] && !sc_ok) ? RESP : ISSUE;
            end
            ISSUE: begin
                rd_nx    = !we_q;
                wr_nx    = we_q;
                state_nx = WAIT_HI;
            end
            WAIT_HI: if (m_busy)  state_nx = WAIT_LO;
            WAIT_LO: if (!m_busy) state_nx = RESP;
            RESP: begin
                done_nx[sel] = 1'b1;
                exok_nx[sel] = ok_q;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            sel      <= '0;
            we_q     <= 1'b0;
            excl_q   <= 1'b0;
            ok_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            res_vld  <= '0;
            for (int j = 0; j < N_PORTS; j++) res_addr[j] <= '0;
            p_gnt    <= '0;
            p_done   <= '0;
            p_exokay <= '0;
            p_rdata  <= '0;
            m_rd_en  <= 1'b0;
            m_wr_en  <= 1'b0;
        end else begin
            state    <= state_nx;
            p_gnt    <= gnt_nx;
            p_done   <= done_nx;
            p_exokay <= exok_nx;
            m_rd_en  <= rd_nx;
            m_wr_en  <= wr_nx;
            if (state == IDLE && !m_busy && found) begin
                sel     <= sel_c;
                we_q    <= p_we[sel_c];
                excl_q  <= p_excl[sel_c];
                ok_q    <= !(p_we[sel_c] && p_excl[sel_c]) || sc_ok;
                waddr_q <= req_addr[W_ADDR-1:2];
                wdata_q <= p_wdata[int'(sel_c)*W_DATA +: W_DATA];
                mask_q  <= p_mask[int'(sel_c)*4 +: 4];
            end
            // Only successful SCs reach ISSUE, so an exclusive write here always clears its own entry.
            if (state == ISSUE) begin
                if (we_q) begin
                    for (int j = 0; j < N_PORTS; j++)
                        if (res_addr[j] == waddr_q) res_vld[j] <= 1'b0;
                    if (excl_q) res_vld[sel] <= 1'b0;
                end else if (excl_q) begin
                    res_vld[sel]  <= 1'b1;
                    res_addr[sel] <= waddr_q;
                end
            end
            if (state == WAIT_LO && !m_busy) p_rdata <= m_rdata;
            if (state == RESP) rr_ptr <= (sel == PW'(N_PORTS-1)) ? '0 : sel + 1'b1;
        end
    end

    assign m_addr  = {waddr_q, 2'b00};
    assign m_wdata = wdata_q;
    assign m_mask  = mask_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: cache_ctrl model plus a transaction-level
// reference of round-robin order, reservations and memory contents.
module tb_sdram_port_arbiter;
    localparam int N = 3, WA = 32, WD = 32;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]    p_req, p_we, p_excl, p_gnt, p_done, p_exokay;
    logic [N*WA-1:0] p_addr;
    logic [N*WD-1:0] p_wdata;
    logic [N*4-1:0]  p_mask;
    logic [WD-1:0]   p_rdata, m_wdata, m_rdata;
    logic [WA-1:0]   m_addr;
    logic [3:0]      m_mask;
    logic            m_rd_en, m_wr_en, m_busy;
    logic            tb_busy = 1'b0;
    int              busy_len = 3;

    sdram_port_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
        .clk(clk), .rst_n(rst_n), .p_req(p_req), .p_we(p_we), .p_excl(p_excl),
        .p_addr(p_addr), .p_wdata(p_wdata), .p_mask(p_mask), .p_gnt(p_gnt),
        .p_done(p_done), .p_exokay(p_exokay), .p_rdata(p_rdata), .m_rd_en(m_rd_en),
        .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
        .m_rdata(m_rdata), .m_busy(m_busy));

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (i == 'h41) ? 32'hDEADBEEF : 32'h1000_0000 + i * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // cache_ctrl model: busy rises the cycle after a strobe and lasts busy_len cycles.
    logic [31:0] cmem [256];
    int bcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt    <= 0;
            m_rdata <= '0;
            for (int i = 0; i < 256; i++) cmem[i] <= init_word(i);
        end else if (m_rd_en || m_wr_en) begin
            bcnt <= busy_len;
            if (m_rd_en) m_rdata <= cmem[m_addr[9:2]];
            else cmem[m_addr[9:2]] <= merge(cmem[m_addr[9:2]], m_wdata, m_mask);
        end else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign m_busy = tb_busy | (bcnt > 0);

    // Reference state
    logic [31:0] rmem [256];
    bit          rv [N];
    logic [29:0] ra [N];
    int          last;
    bit          pend [N], pwe [N], pex [N];
    logic [31:0] pad [N], pwd [N];
    logic [3:0]  pmk [N];
    int          left [N];
    int          act, gcyc, now, pulses, a_lat;
    bit          a_ok, a_iss, a_we;
    logic [31:0] a_rd, a_addr, a_wd;
    logic [3:0]  a_mk;
    int          nchk = 0, nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
        for (int i = 0; i < N; i++) begin rv[i] = 0; pend[i] = 0; left[i] = 0; end
        last = N - 1;
        act  = -1;
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_gnt"}, 32'(p_gnt), 0);
        chk({tag, "_done"}, 32'(p_done), 0);
        chk({tag, "_exokay"}, 32'(p_exokay), 0);
        chk({tag, "_rdata"}, p_rdata, 0);
        chk({tag, "_strobes"}, {30'b0, m_rd_en, m_wr_en}, 0);
        chk({tag, "_maddr"}, m_addr, 0);
        chk({tag, "_mwdata"}, m_wdata, 0);
        chk({tag, "_mmask"}, 32'(m_mask), 0);
    endtask

    task automatic post(input int p, input bit we, input bit ex, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
        pend[p] = 1; pwe[p] = we; pex[p] = ex; pad[p] = a; pwd[p] = d; pmk[p] = m;
        p_we[p] = we; p_excl[p] = ex;
        p_addr[p*WA +: WA]  = a;
        p_wdata[p*WD +: WD] = d;
        p_mask[p*4 +: 4]    = m;
        p_req[p] = 1'b1;
    endtask

    task automatic post_rand(input int p);
        post(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'h200 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3),
             $urandom, 4'($urandom_range(1, 15)));
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1;
        return 0;
    endfunction

    function automatic int pick();
        for (int k = 1; k <= N; k++) if (pend[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Spec-level effect of one granted access on reservations and memory.
    task automatic start_access(input int g);
        act = g; gcyc = now; pulses = 0;
        a_we = pwe[g]; a_addr = pad[g]; a_wd = pwd[g]; a_mk = pmk[g];
        a_ok  = (pwe[g] && pex[g]) ? (rv[g] && ra[g] == pad[g][31:2]) : 1'b1;
        a_iss = !(pwe[g] && pex[g]) || a_ok;
        if (a_iss && pwe[g]) begin
            rmem[pad[g][9:2]] = merge(rmem[pad[g][9:2]], pwd[g], pmk[g]);
            for (int j = 0; j < N; j++) if (ra[j] == pad[g][31:2]) rv[j] = 0;
            if (pex[g]) rv[g] = 0;
        end
        if (!pwe[g]) begin
            a_rd = rmem[pad[g][9:2]];
            if (pex[g]) begin rv[g] = 1; ra[g] = pad[g][31:2]; end
        end
        a_lat = a_iss ? 4 + busy_len : 1;
        pend[g] = 0;
        p_req[g] = 1'b0;
    endtask

    task automatic run(input int maxc);
        int g, p;
        for (int cyc = 0; cyc < maxc; cyc++) begin
            if (act < 0 && !any_pend()) break;
            @(posedge clk); #1; now++;
            if (m_rd_en || m_wr_en) begin
                pulses++;
                chk("strobe_kind", {30'b0, m_rd_en, m_wr_en}, a_we ? 1 : 2);
                chk("m_addr", m_addr, {a_addr[31:2], 2'b00});
                chk("m_mask", 32'(m_mask), 32'(a_mk));
                if (a_we) chk("m_wdata", m_wdata, a_wd);
            end
            if (p_gnt != 0) begin
                g = (act >= 0) ? -1 : pick();
                chk("gnt", 32'(p_gnt), (g < 0) ? 0 : (1 << g));
                if (g >= 0) start_access(g);
            end
            if (p_done != 0) begin
                chk("done", 32'(p_done), (act < 0) ? 0 : (1 << act));
                if (act >= 0) begin
                    chk("latency", now - gcyc, a_lat);
                    chk("exokay", 32'(p_exokay), a_ok ? (1 << act) : 0);
                    chk("strobe_count", pulses, a_iss ? 1 : 0);
                    if (!a_we) chk("rdata", p_rdata, a_rd);
                    last = act; p = act; act = -1;
                    if (left[p] > 0) begin left[p]--; post_rand(p); end
                end
            end
        end
        chk("run_idle", {31'b0, (act < 0 && !any_pend())}, 1);
    endtask

    initial begin
        int hi;
        p_req = '0; p_we = '0; p_excl = '0; p_addr = '0; p_wdata = '0; p_mask = '0;
        now = 0;
        ref_reset();
        repeat (2) @(posedge clk);
        #1 zero_check("reset");
        @(negedge clk) rst_n = 1'b1;

        // Busy held in IDLE blocks grants; then ports 0/1 request continuously.
        tb_busy = 1'b1;
        post(0, 0, 0, 32'h080, 0, 4'hF);
        post(1, 0, 0, 32'h084, 0, 4'hF);
        repeat (4) begin @(posedge clk); #1 chk("gnt_while_busy", 32'(p_gnt), 0); end
        tb_busy = 1'b0;
        left[0] = 2; left[1] = 2;
        run(300);

        // Single read with 3 busy cycles.
        busy_len = 3;
        post(0, 0, 0, 32'h104, 0, 4'hF);
        run(60);

        // LR, successful SC, repeated SC fails.
        post(0, 0, 1, 32'h200, 0, 4'hF);           run(60);
        post(0, 1, 1, 32'h200, 32'h5, 4'hF);       run(60);
        post(0, 1, 1, 32'h200, 32'h7, 4'hF);       run(60);
        // LR, other port writes same word, SC fails.
        post(0, 0, 1, 32'h200, 0, 4'hF);           run(60);
        post(1, 1, 0, 32'h202, 32'h00AB_0000, 4'h4); run(60);
        post(0, 1, 1, 32'h200, 32'h9, 4'hF);       run(60);
        post(2, 0, 0, 32'h200, 0, 4'hF);           run(60);
        // Unaligned write.
        post(1, 1, 0, 32'h13, 32'hCC00_0000, 4'h8); run(60);
        post(0, 0, 0, 32'h10, 0, 4'hF);            run(60);

        // Random traffic from all ports with varying busy lengths.
        for (int r = 0; r < 4; r++) begin
            busy_len = $urandom_range(1, 4);
            for (int p = 0; p < N; p++) begin left[p] = 5; post_rand(p); end
            run(2000);
        end

        // Reset during WAIT_LO.
        busy_len = 5; hi = 0;
        post(1, 0, 0, 32'h300, 0, 4'hF);
        for (int c = 0; c < 40 && hi < 2; c++) begin
            @(posedge clk); #1;
            if (p_gnt != 0) p_req = '0;
            if (m_busy) hi++;
        end
        chk("reach_wait_lo", hi, 2);
        rst_n = 1'b0;
        #1 zero_check("mid_reset");
        repeat (3) begin @(posedge clk); #1 chk("no_done_in_reset", 32'(p_done), 0); end
        p_req = '0;
        ref_reset();
        @(negedge clk) rst_n = 1'b1;
        busy_len = 2;
        post(2, 0, 0, 32'h104, 0, 4'hF);
        run(60);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
